// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared arbiter states, memory size and the access range check
package dmem_arbiter_pkg;
  typedef enum logic {ARB_PIPE = 1'b0, ARB_FORCE = 1'b1} arb_state_t;
  localparam int DMEM_BYTES = 1024;
  localparam int DMEM_MAX_WAIT = 4;
  function automatic logic addr_err(input logic [63:0] addr, input int bytes);
    return addr > 64'(bytes - 8);
  endfunction
endpackage

// File: rtl/dmem_fair_counter.sv
// dmem_fair_counter: counts consecutive denied loader cycles and forces one loader slot
import dmem_arbiter_pkg::*;
module dmem_fair_counter #(
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic l_req_i,
  input  logic l_gnt_i,
  output logic force_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  arb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  // state and wait counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_PIPE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // a forced slot always lasts one cycle; a denial grows the count until it triggers one
  always_comb begin
    state_n = ARB_PIPE;
    cnt_n = '0;
    if (state == ARB_PIPE && l_req_i && !l_gnt_i) begin
      cnt_n = (cnt == CW'(MAX_WAIT)) ? cnt : cnt + 1'b1;
      state_n = (cnt_n == CW'(MAX_WAIT)) ? ARB_FORCE : ARB_PIPE;
    end
  end
  assign force_o = state == ARB_FORCE;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between M stage and loader; fairness slot under DMEM_ARB_FAIRNESS_EN
import dmem_arbiter_pkg::*;
module dmem_arbiter #(
  parameter int MEM_BYTES = DMEM_BYTES
`ifdef DMEM_ARB_FAIRNESS_EN
  , parameter int MAX_WAIT = DMEM_MAX_WAIT
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p_read_i,
  input  logic        p_write_i,
  input  logic [63:0] p_addr_i,
  input  logic [63:0] p_wdata_i,
  output logic [63:0] p_rdata_o,
  output logic        p_err_o,
  output logic        p_stall_o,
  input  logic        l_req_i,
  input  logic        l_we_i,
  input  logic [63:0] l_addr_i,
  input  logic [63:0] l_wdata_i,
  output logic        l_gnt_o,
  output logic        l_rvalid_o,
  output logic [63:0] l_rdata_o,
  output logic        l_err_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_wdata_o,
  output logic        ram_read_o,
  output logic        ram_write_o,
  input  logic [63:0] ram_rdata_i
);
  logic p_req, forced, p_own, pa_err, la_err;
  assign p_req = p_read_i | p_write_i;
  assign pa_err = addr_err(p_addr_i, MEM_BYTES);
  assign la_err = addr_err(l_addr_i, MEM_BYTES);
`ifdef DMEM_ARB_FAIRNESS_EN
  logic force_w;
  dmem_fair_counter #(.MAX_WAIT(MAX_WAIT)) u_fair (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .l_req_i(l_req_i),
    .l_gnt_i(l_gnt_o),
    .force_o(force_w)
  );
  assign forced = force_w & l_req_i;
`else
  assign forced = 1'b0;
`endif
  assign p_own = p_req & !forced;
  // ownership mux; a simultaneous read+write from M is handled as a write
  always_comb begin
    l_gnt_o = l_req_i & !p_own;
    p_stall_o = forced & p_req;
    p_err_o = p_req & pa_err;
    ram_addr_o = p_own ? p_addr_i : l_gnt_o ? l_addr_i : '0;
    ram_wdata_o = p_own ? p_wdata_i : l_gnt_o ? l_wdata_i : '0;
    ram_write_o = p_own ? p_write_i & !pa_err : l_gnt_o & l_we_i & !la_err;
    ram_read_o = p_own ? !p_write_i & !pa_err : l_gnt_o & !l_we_i & !la_err;
    p_rdata_o = (p_own & !p_write_i & !pa_err) ? ram_rdata_i : '0;
  end
  // loader return is registered one cycle after its grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_rvalid_o <= 1'b0;
      l_rdata_o <= '0;
      l_err_o <= 1'b0;
    end else begin
      l_rvalid_o <= l_gnt_o & !l_we_i;
      l_rdata_o <= (l_gnt_o & !l_we_i & !la_err) ? ram_rdata_i : '0;
      l_err_o <= l_gnt_o & la_err;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a byte-level memory model
module tb_dmem_arbiter;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int MAXW = 4;
  logic clk_i = 1'b0;
  logic rst_i;
  logic p_read_i, p_write_i, l_req_i, l_we_i;
  logic [63:0] p_addr_i, p_wdata_i, l_addr_i, l_wdata_i;
  logic [63:0] p_rdata_o, l_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic p_err_o, p_stall_o, l_gnt_o, l_rvalid_o, l_err_o, ram_read_o, ram_write_o;
  logic [7:0] ram_mem [1024];
  logic [7:0] ref_mem [1024];
  logic [9:0] ra;
  int total = 0, bad = 0, den = 0, gcnt, scnt;
  logic e_rvalid = 1'b0, e_err = 1'b0, e_gprev = 1'b0;
  logic [63:0] e_rdata = '0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p_read_i(p_read_i), .p_write_i(p_write_i), .p_addr_i(p_addr_i), .p_wdata_i(p_wdata_i),
    .p_rdata_o(p_rdata_o), .p_err_o(p_err_o), .p_stall_o(p_stall_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
    .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o), .l_err_o(l_err_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_read_o(ram_read_o),
    .ram_write_o(ram_write_o), .ram_rdata_i(ram_rdata_i)
  );

  assign ra = ram_addr_o[9:0];
  assign ram_rdata_i = (ram_read_o && ram_addr_o <= 64'd1016) ?
    {ram_mem[ra+10'd7], ram_mem[ra+10'd6], ram_mem[ra+10'd5], ram_mem[ra+10'd4],
     ram_mem[ra+10'd3], ram_mem[ra+10'd2], ram_mem[ra+10'd1], ram_mem[ra]} : 64'h0;

  always @(posedge clk_i)
    if (ram_write_o && ram_addr_o <= 64'd1016)
      for (int i = 0; i < 8; i++) ram_mem[int'(ra) + i] <= ram_wdata_o[8*i +: 8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
    return r;
  endfunction

  task automatic step(input logic rd, input logic wr, input logic lr, input logic lwe,
                      input logic [63:0] pa, input logic [63:0] pwd,
                      input logic [63:0] la, input logic [63:0] lwd, input logic rs);
    logic preq, perr, lerr, forced, pown, gnt, wexp;
    logic [63:0] wa, wd;
    @(negedge clk_i);
    rst_i = rs; p_read_i = rd; p_write_i = wr; p_addr_i = pa; p_wdata_i = pwd;
    l_req_i = lr; l_we_i = lwe; l_addr_i = la; l_wdata_i = lwd;
    #1;
    chk("l_rvalid", {63'b0, l_rvalid_o}, {63'b0, e_rvalid});
    if (e_rvalid) chk("l_rdata", l_rdata_o, e_rdata);
    if (e_gprev) chk("l_err", {63'b0, l_err_o}, {63'b0, e_err});
    preq = rd | wr;
    perr = pa > 64'd1016;
    lerr = la > 64'd1016;
    forced = FAIR && den == MAXW && lr;
    pown = preq && !forced;
    gnt = lr && !pown;
    wexp = pown ? (wr && !perr) : (gnt && lwe && !lerr);
    wa = pown ? pa : gnt ? la : 64'h0;
    wd = pown ? pwd : lwd;
    chk("p_stall", {63'b0, p_stall_o}, {63'b0, forced && preq});
    chk("l_gnt", {63'b0, l_gnt_o}, {63'b0, gnt});
    chk("p_err", {63'b0, p_err_o}, {63'b0, preq && perr});
    if (pown) chk("p_rdata", p_rdata_o, (rd && !wr && !perr) ? ref_rd(pa) : 64'h0);
    chk("ram_write", {63'b0, ram_write_o}, {63'b0, wexp});
    chk("ram_addr", ram_addr_o, wa);
    if (wexp) chk("ram_wdata", ram_wdata_o, wd);
    e_rvalid = !rs && gnt && !lwe;
    e_rdata = (gnt && !lwe && !lerr) ? ref_rd(la) : 64'h0;
    e_err = !rs && gnt && lerr;
    e_gprev = !rs && gnt;
    if (rs || (FAIR && den == MAXW)) den = 0;
    else den = (lr && !gnt) ? den + 1 : 0;
    if (wexp) for (int i = 0; i < 8; i++) ref_mem[int'(wa[9:0]) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(7))
      0: return 64'h3F8;
      1: return 64'h3F9;
      2: return 64'h400;
      3: return 64'hFFFF_FFFF_FFFF_FFF8;
      default: return 64'($urandom_range(95));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 8'h0;
      ref_mem[i] = 8'h0;
    end
    rst_i = 1'b1; p_read_i = 0; p_write_i = 0; p_addr_i = 0; p_wdata_i = 0;
    l_req_i = 0; l_we_i = 0; l_addr_i = 0; l_wdata_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rst_stall", {63'b0, p_stall_o}, 64'h0);
    chk("rst_gnt", {63'b0, l_gnt_o}, 64'h0);
    chk("rst_rvalid", {63'b0, l_rvalid_o}, 64'h0);
    chk("rst_rdata", l_rdata_o, 64'h0);
    chk("rst_err", {63'b0, l_err_o}, 64'h0);
    chk("rst_idle_addr", ram_addr_o, 64'h0);
    step(0, 0, 1, 1, 0, 0, 64'h10, 64'h1122334455667788, 0);
    chk("t1_gnt", {63'b0, l_gnt_o}, 64'h1);
    step(1, 0, 0, 0, 64'h10, 0, 0, 0, 0);
    chk("t1_valm", p_rdata_o, 64'h1122334455667788);
    step(0, 0, 1, 0, 0, 0, 64'h10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rvalid", {63'b0, l_rvalid_o}, 64'h1);
    chk("t2_rdata", l_rdata_o, 64'h1122334455667788);
    chk("t2_err", {63'b0, l_err_o}, 64'h0);
    step(1, 0, 0, 0, 64'h3F8, 0, 0, 0, 0);
    chk("t3_err_3f8", {63'b0, p_err_o}, 64'h0);
    step(1, 0, 0, 0, 64'h3F9, 0, 0, 0, 0);
    chk("t3_err_3f9", {63'b0, p_err_o}, 64'h1);
    chk("t3_rdata_3f9", p_rdata_o, 64'h0);
    step(0, 1, 0, 0, 64'h3F9, 64'hDEAD, 0, 0, 0);
    chk("t3_wr_3f9", {63'b0, ram_write_o}, 64'h0);
    gcnt = 0; scnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 1, 0, 64'h20, 0, 64'h30, 0, 0);
      gcnt += int'(l_gnt_o);
      scnt += int'(p_stall_o);
    end
    chk("t45_grants", 64'(gcnt), FAIR ? 64'd4 : 64'd0);
    chk("t45_stalls", 64'(scnt), FAIR ? 64'd4 : 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 64'h10, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rvalid", {63'b0, l_rvalid_o}, 64'h0);
    for (int c = 0; c < 3; c++) step(1, 0, 1, 0, 64'h8, 0, 64'h18, 0, 0);
    step(1, 0, 1, 0, 64'h8, 0, 64'h18, 0, 1);
    for (int c = 0; c < 6; c++) step(1, 0, 1, 0, 64'h8, 0, 64'h18, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic rd, wr;
      rd = $urandom_range(2) == 0;
      wr = $urandom_range(2) == 0;
      step(rd, wr, $urandom_range(1) == 1, $urandom_range(1) == 1,
           pick_addr(), {$urandom, $urandom}, pick_addr(), {$urandom, $urandom},
           $urandom_range(39) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
